// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch (IF) and load/store (LS) requesters.
// One access outstanding at a time; a starvation counter lets IF win after STARVE_MAX lost contests.
module mem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_w_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   starve_cnt, starve_nxt;
  logic [CW-1:0]   wait_cnt, wait_nxt;
  logic            own_ls, we_q;
  logic            both, if_win, ls_win, in_idle;

  always_comb begin
    both    = if_req && ls_req;
    if_win  = if_req && (!ls_req || starve_cnt == SW'(STARVE_MAX));
    ls_win  = ls_req && !if_win;
    in_idle = (state == IDLE) && !rst;
  end

  assign if_gnt    = in_idle && if_win;
  assign ls_gnt    = in_idle && ls_win;
  assign if_rvalid = (state == RESP) && !own_ls && !rst;
  assign ls_rvalid = (state == RESP) && own_ls && !rst;
  assign if_rdata  = if_rvalid ? ram_rdata : '0;
  assign ls_rdata  = ls_rvalid ? ram_rdata : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    wait_nxt   = wait_cnt;
    case (state)
      IDLE: begin
        if (if_gnt || ls_gnt) state_nxt = ACCESS;
        // LS wins a contest only below STARVE_MAX, so the increment saturates there
        if (!if_req || if_gnt)
          starve_nxt = '0;
        else if (both && starve_cnt != SW'(STARVE_MAX))
          starve_nxt = starve_cnt + 1'b1;
      end
      ACCESS: begin
        if (we_q)
          state_nxt = IDLE;
        else if (RD_LAT == 1)
          state_nxt = RESP;
        else begin
          state_nxt = WAIT;
          wait_nxt  = CW'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (wait_cnt == CW'(1))
          state_nxt = RESP;
        else
          wait_nxt = wait_cnt - 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      own_ls     <= 1'b0;
      we_q       <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_w_en   <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      wait_cnt   <= wait_nxt;
      ram_w_en   <= ls_gnt && ls_we;
      // ram_addr holds from ACCESS through RESP since grants only occur in IDLE
      if (if_gnt) begin
        own_ls   <= 1'b0;
        we_q     <= 1'b0;
        ram_addr <= if_addr;
      end else if (ls_gnt) begin
        own_ls    <= 1'b1;
        we_q      <= ls_we;
        ram_addr  <= ls_addr;
        ram_wdata <= ls_wdata;
      end
    end
  end
endmodule
